key_event_tx: RTL and testbench
===============================

Name: key_event_tx

Overview:
- Sits between the camera key-detection output and the uart byte transmitter.
- Takes a per-frame bitmap of pressed piano keys and detects keys whose state changed since the last accepted frame.
- Queues each change as an event and serialises it to the uart as a 2-byte MIDI-style message: a status byte followed by a note byte.

Parameters:
- NKEYS, 16, number of keys in the bitmap (1..64).
- FIFO_DEPTH, 8, event queue depth (power of 2, >=2).
- BASE_NOTE, 60, note number sent for key 0; key i sends BASE_NOTE+i (NKEYS+BASE_NOTE <= 128).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_state  in  NKEYS  pressed bitmap, 1 = pressed; valid when key_valid=1
- key_valid  in  1  one-cycle frame strobe
- send  out  1  one-cycle request to uart to transmit send_data
- send_data  out  8  byte to transmit; stable from send until send_done
- send_done  in  1  uart finished current byte (sampled high = done)
- busy  out  1  scan active or FIFO non-empty or TX not idle
- frame_drop  out  1  sticky: a frame arrived while scanning; cleared only by reset
- sta  out  4  debug: {scan_state, tx_state[2:0]} for seven-segment display

Behaviour:
- Reset, asynchronous while rst=0:
  - Outputs: send=0, send_data=0, busy=0, frame_drop=0.
  - Internal: prev bitmap=0, FIFO empty, both FSMs idle, last_status=none.
- Scanner FSM:
  - S_IDLE: on key_valid, latch diff=key_state^prev and prev=key_state, clear index, go to S_SCAN. If diff=0, the scan still runs (no events).
  - S_SCAN: each cycle examine diff[index].
    - If set and FIFO not full: push {on=key_state_latched[index], index}, then index++.
    - If set and FIFO full: stall with index held. No push even when a pop occurs the same cycle.
    - If clear: index++.
    - After index NKEYS-1 is handled, return to S_IDLE.
  - Latency: key i is examined at cycle N+1+i plus stall cycles, where N is the key_valid cycle.
  - key_valid while in S_SCAN: frame ignored, prev unchanged, frame_drop set. Changes are still reported on the next accepted frame, so no transition is lost.
- FIFO:
  - Entry = on bit + ceil(log2 NKEYS) index bits.
  - Push and pop in the same cycle are both honoured when not full and not empty.
  - Occupancy never exceeds FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
- TX FSM:
  - T_IDLE: if FIFO non-empty, pop the head into a holding register, then go to T_STAT.
  - T_STAT: send=1 for one cycle with send_data=0x90 (on) or 0x80 (off), then go to T_WAIT0.
  - T_WAIT0: wait for send_done=1, then go to T_NOTE.
  - T_NOTE: send=1 for one cycle with send_data=BASE_NOTE+index (7-bit, MSB 0), then go to T_WAIT1.
  - T_WAIT1: wait for send_done=1, then go to T_IDLE.
  - A send_done seen in any other state is ignored.
  - Minimum message time is 5 cycles plus the uart time.
- busy is combinational from the state and FIFO-empty flag.
- Reset mid-message: the message is abandoned, and the uart is left to finish its current byte on its own.

Optional Feature:
- RUNNING_STATUS_EN defined:
  - T_STAT is skipped (go directly to T_NOTE) when the event's status byte equals last_status.
  - last_status is updated whenever a status byte is sent, and resets to none, so the first event always sends status.
- Undefined: every message is 2 bytes.

Decomposition:
- Shared package holds:
  - constants STATUS_ON=8'h90 and STATUS_OFF=8'h80;
  - scanner state encodings S_IDLE/S_SCAN;
  - TX state encodings T_IDLE/T_STAT/T_WAIT0/T_NOTE/T_WAIT1.
- One sub-module, event_fifo: a parameterised synchronous FIFO with push, pop, full, empty and count.

Test Plan:
- Reset, then one frame key_state=16'h0005 -> bytes 90 3C, 90 3E, in that order; busy then falls to 0.
- Next frame key_state=16'h0004 -> bytes 80 3C only.
- Frame 16'hFFFF from all released, FIFO_DEPTH=8, uart send_done delayed 20 cycles -> scanner stalls at index 8 or above; all 16 note-ons are sent in index order with none lost.
- key_valid pulsed again 3 cycles after a frame -> frame_drop=1 and the second frame ignored; the next accepted frame reports the net change vs the first frame.
- rst asserted during T_WAIT0 -> send=0 and busy=0 immediately; FIFO empty; after release, frame 16'h0001 -> 90 3C.
- With RUNNING_STATUS_EN, frame 16'h0003 -> 90 3C 3D (3 bytes).

Source files
------------

// File: rtl/key_event_tx_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module  : key_event_tx_pkg                                                   |
// | Purpose : Shared constants and state encodings for the key event            |
// |           transmitter (MIDI status bytes, scanner and TX FSM states).       |
// | Rev     : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package key_event_tx_pkg;

  localparam logic [7:0] STATUS_ON  = 8'h90;
  localparam logic [7:0] STATUS_OFF = 8'h80;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } scan_state_t;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_STAT  = 3'd1,
    T_WAIT0 = 3'd2,
    T_NOTE  = 3'd3,
    T_WAIT1 = 3'd4
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/key_event_tx_fifo.sv
// +-----------------------------------------------------------------------------+
// | Module  : event_fifo                                                         |
// | Purpose : Synchronous FIFO holding key change events.                       |
// |           Push is honoured when not full, pop when not empty; both may      |
// |           happen in the same cycle.  DEPTH must be a power of two >= 2 so   |
// |           the pointers wrap naturally.                                      |
// | Ports   : clk, rst (async active-low), push/push_data, pop/pop_data        |
// |           (head, valid while !empty), full, empty, count (occupancy).      |
// | Rev     : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module event_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/key_event_tx.sv
// +-----------------------------------------------------------------------------+
// | Module  : key_event_tx                                                       |
// | Purpose : Detects piano keys whose state changed between accepted frames,  |
// |           queues each change and sends it to a uart as a status byte       |
// |           (0x90 on / 0x80 off) followed by a note byte (BASE_NOTE+index).  |
// | Ports   : clk, rst (async active-low)                                       |
// |           key_state/key_valid : frame bitmap and one-cycle strobe          |
// |           send/send_data      : byte request to uart, data held until done |
// |           send_done           : uart finished current byte                 |
// |           busy                : scanning, events queued or TX active       |
// |           frame_drop          : sticky, frame arrived while scanning       |
// |           sta                 : {scan_state, tx_state} debug               |
// | Macro   : RUNNING_STATUS_EN - omit the status byte when it equals the last |
// |           status byte sent (first message after reset always sends it).    |
// | Rev     : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module key_event_tx
  import key_event_tx_pkg::*;
#(
  parameter int NKEYS      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int BASE_NOTE  = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_state,
  input  logic             key_valid,
  output logic             send,
  output logic [7:0]       send_data,
  input  logic             send_done,
  output logic             busy,
  output logic             frame_drop,
  output logic [3:0]       sta
);

  localparam int IDX_W = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int ENT_W = IDX_W + 1;

  // ---------------------------------------------------------------- scanner
  scan_state_t      scan_state;
  scan_state_t      scan_next;
  logic [NKEYS-1:0] prev;
  logic [NKEYS-1:0] diff;
  logic [IDX_W-1:0] index;
  logic             advance;
  logic             last_key;

  logic             push;
  logic [ENT_W-1:0] push_data;
  logic             pop;
  logic [ENT_W-1:0] pop_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign last_key = (index == IDX_W'(NKEYS - 1));

  // A changed key waits (index held) until the queue has room.
  always_comb begin
    advance   = 1'b0;
    push      = 1'b0;
    scan_next = scan_state;
    case (scan_state)
      S_IDLE: begin
        if (key_valid) scan_next = S_SCAN;
      end
      S_SCAN: begin
        if (diff[index]) begin
          push    = !fifo_full;
          advance = !fifo_full;
        end else begin
          advance = 1'b1;
        end
        if (advance && last_key) scan_next = S_IDLE;
      end
      default: scan_next = S_IDLE;
    endcase
  end

  // prev already holds the frame being scanned, so it doubles as the
  // latched key state for the on/off bit.
  assign push_data = {prev[index], index};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_state <= S_IDLE;
    end else begin
      scan_state <= scan_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev       <= '0;
      diff       <= '0;
      index      <= '0;
      frame_drop <= 1'b0;
    end else begin
      if (scan_state == S_IDLE) begin
        if (key_valid) begin
          diff  <= key_state ^ prev;
          prev  <= key_state;
          index <= '0;
        end
      end else begin
        // prev is left alone, so the next accepted frame still reports
        // the net change relative to the frame being scanned now.
        if (key_valid) frame_drop <= 1'b1;
        if (advance)   index <= index + IDX_W'(1);
      end
    end
  end

  event_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // --------------------------------------------------------------------- TX
  tx_state_t        tx_state;
  tx_state_t        tx_next;
  logic             hold_on;
  logic [IDX_W-1:0] hold_idx;
  logic [7:0]       status_byte;
  logic [7:0]       note_byte;
  logic [7:0]       head_status;

  assign status_byte = hold_on ? STATUS_ON : STATUS_OFF;
  assign note_byte   = {1'b0, 7'(BASE_NOTE + int'(hold_idx))};
  assign head_status = pop_data[ENT_W-1] ? STATUS_ON : STATUS_OFF;

`ifdef RUNNING_STATUS_EN
  logic       last_valid;
  logic [7:0] last_status;
`endif

  // send_data is decoded from the state and holding register, which keeps
  // it stable through the wait state until the uart reports done.
  always_comb begin
    tx_next   = tx_state;
    pop       = 1'b0;
    send      = 1'b0;
    send_data = 8'h00;
    case (tx_state)
      T_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          tx_next = T_STAT;
`ifdef RUNNING_STATUS_EN
          if (last_valid && (last_status == head_status)) tx_next = T_NOTE;
`endif
        end
      end
      T_STAT: begin
        send      = 1'b1;
        send_data = status_byte;
        tx_next   = T_WAIT0;
      end
      T_WAIT0: begin
        send_data = status_byte;
        if (send_done) tx_next = T_NOTE;
      end
      T_NOTE: begin
        send      = 1'b1;
        send_data = note_byte;
        tx_next   = T_WAIT1;
      end
      T_WAIT1: begin
        send_data = note_byte;
        if (send_done) tx_next = T_IDLE;
      end
      default: tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= T_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_on  <= 1'b0;
      hold_idx <= '0;
    end else if (pop) begin
      hold_on  <= pop_data[ENT_W-1];
      hold_idx <= pop_data[IDX_W-1:0];
    end
  end

`ifdef RUNNING_STATUS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_valid  <= 1'b0;
      last_status <= 8'h00;
    end else if (tx_state == T_STAT) begin
      last_valid  <= 1'b1;
      last_status <= status_byte;
    end
  end
`endif

  assign busy = (scan_state != S_IDLE) || (fifo_count != '0) || (tx_state != T_IDLE);
  assign sta  = {1'(scan_state), 3'(tx_state)};

endmodule

`default_nettype wire

// File: tb/tb_key_event_tx.sv
// +-----------------------------------------------------------------------------+
// | Module  : tb_key_event_tx                                                    |
// | Purpose : Self-checking bench for key_event_tx.  A frame-level model turns  |
// |           each accepted bitmap into the expected byte stream; a uart model |
// |           consumes send requests with random or fixed latency and compares |
// |           every byte.  Honours RUNNING_STATUS_EN in its model.             |
// | Rev     : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_key_event_tx;
  import key_event_tx_pkg::*;

  localparam int NKEYS      = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int BASE_NOTE  = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] key_state = '0;
  logic        key_valid = 1'b0;
  logic        send;
  logic [7:0]  send_data;
  logic        send_done = 1'b0;
  logic        busy;
  logic        frame_drop;
  logic [3:0]  sta;

  always #5 clk = ~clk;

  key_event_tx #(
    .NKEYS      (NKEYS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BASE_NOTE  (BASE_NOTE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_state  (key_state),
    .key_valid  (key_valid),
    .send       (send),
    .send_data  (send_data),
    .send_done  (send_done),
    .busy       (busy),
    .frame_drop (frame_drop),
    .sta        (sta)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  logic [15:0] m_prev = '0;
  int          m_last = -1;   // -1: no status byte sent since reset
  logic [7:0]  exp_q[$];

  task automatic model_frame(input logic [15:0] f);
    logic [15:0] d;
    int          st;
    d = f ^ m_prev;
    for (int i = 0; i < NKEYS; i++) begin
      if (d[i]) begin
        st = f[i] ? 'h90 : 'h80;
`ifdef RUNNING_STATUS_EN
        if (st != m_last) exp_q.push_back(8'(st));
        m_last = st;
`else
        exp_q.push_back(8'(st));
`endif
        exp_q.push_back(8'(BASE_NOTE + i));
      end
    end
    m_prev = f;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = '0;
    m_last = -1;
  endtask

  // ------------------------------------------------------------ uart model
  int uart_delay  = 0;   // 0: random 1..4 cycles
  int rst_epoch   = 0;
  bit uart_active = 1'b0;
  int bytes_seen  = 0;

  initial begin
    logic [7:0] b;
    int         ep;
    int         d;
    #1;
    forever begin
      if (send === 1'b1) begin
        b  = send_data;
        ep = rst_epoch;
        uart_active = 1'b1;
        bytes_seen++;
        if (exp_q.size() == 0) check("byte_unexpected", {24'd0, b}, 32'h100);
        else                   check("byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
        d = (uart_delay != 0) ? uart_delay : int'($urandom_range(1, 4));
        repeat (d) begin
          @(posedge clk); #1;
          if (ep == rst_epoch && rst) check("data_stable", {24'd0, send_data}, {24'd0, b});
        end
        send_done = 1'b1;
        @(posedge clk); #1;
        send_done   = 1'b0;
        uart_active = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic apply_frame(input logic [15:0] f);
    @(negedge clk);
    key_state = f;
    key_valid = 1'b1;
    model_frame(f);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_scan_idle();
    for (int c = 0; c < 2000 && sta[3]; c++) @(negedge clk);
    check("scan_idle_timeout", {31'd0, sta[3]}, 32'd0);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 5000 && (exp_q.size() != 0 || busy || uart_active); c++) @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rst_epoch++;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 200 && uart_active; c++) @(negedge clk);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- sequence
  initial begin
    int          scan_cycles;
    int          b0;
    logic [15:0] a;

    repeat (3) @(posedge clk);
    #1;
    check("rst_send",       {31'd0, send},       32'd0);
    check("rst_send_data",  {24'd0, send_data},  32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_frame_drop", {31'd0, frame_drop}, 32'd0);
    check("rst_sta",        {28'd0, sta},        32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Two presses then one release.
    apply_frame(16'h0005);
    drain("f0005");
    apply_frame(16'h0004);
    drain("f0004");

    // Full press with a slow uart forces the scanner to stall.
    apply_frame(16'h0000);
    drain("f0000");
    uart_delay = 20;
    apply_frame(16'hFFFF);
    scan_cycles = 0;
    for (int c = 0; c < 2000 && sta[3]; c++) begin
      scan_cycles++;
      @(negedge clk);
    end
    check("stall", {31'd0, (scan_cycles > NKEYS)}, 32'd1);
    drain("fFFFF");
    uart_delay = 0;
    check("no_drop_yet", {31'd0, frame_drop}, 32'd0);

    // Frame arriving during a scan is dropped.
    a = 16'($urandom);
    apply_frame(a);
    repeat (2) @(negedge clk);
    key_state = ~a;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("frame_drop_set", {31'd0, frame_drop}, 32'd1);
    drain("drop_a");
    apply_frame(16'($urandom));
    drain("drop_next");
    check("frame_drop_sticky", {31'd0, frame_drop}, 32'd1);

    // Random frames back to back, TX overlapping with scans.
    for (int k = 0; k < 25; k++) begin
      wait_scan_idle();
      repeat ($urandom_range(0, 6)) @(negedge clk);
      apply_frame(16'($urandom));
    end
    drain("random");

    // Reset while the TX waits for the status byte to finish.
    uart_delay = 20;
    apply_frame(m_prev ^ 16'hF0F0);
    for (int c = 0; c < 500 && sta[2:0] != 3'(T_WAIT0); c++) @(negedge clk);
    check("reach_wait0", {29'd0, sta[2:0]}, {29'd0, 3'(T_WAIT0)});
    #2;
    rst = 1'b0;
    rst_epoch++;
    model_reset();
    #1;
    check("mid_rst_send",       {31'd0, send},       32'd0);
    check("mid_rst_busy",       {31'd0, busy},       32'd0);
    check("mid_rst_send_data",  {24'd0, send_data},  32'd0);
    check("mid_rst_sta",        {28'd0, sta},        32'd0);
    check("mid_rst_frame_drop", {31'd0, frame_drop}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 200 && uart_active; c++) @(negedge clk);
    uart_delay = 0;
    b0 = bytes_seen;
    apply_frame(16'h0001);
    drain("after_rst");
    check("after_rst_bytes", bytes_seen - b0, 32'd2);

    // Two presses of the same kind from a clean reset.
    do_reset();
    b0 = bytes_seen;
    apply_frame(16'h0003);
    drain("f0003");
`ifdef RUNNING_STATUS_EN
    check("f0003_bytes", bytes_seen - b0, 32'd3);
`else
    check("f0003_bytes", bytes_seen - b0, 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
